alarm_unit: RTL and testbench
=============================

# alarm_unit

Alarm controller that sits downstream of the timekeeping counter. It consumes the running hours/minutes/seconds value and its once-per-second strobe, and holds a programmable alarm time that is loaded through a valid/ready handshake. It drives a `ring` output for a bounded duration and supports stop and snooze. It is the consumer and comparator end of the time bus that the clock counter produces.

## Interface
Parameters:
- `RING_SECONDS`, default 60: number of `sec_tick` strobes `ring` stays high before timing out (legal range 1–255).
- `SNOOZE_MINUTES`, default 5: re-ring delay after a snooze (legal range 1–59).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `sec_tick` in 1: one-cycle strobe; time inputs hold the new value from this cycle until the next strobe.
- `hours` in 5: current hour, 0–23.
- `minutes` in 6: current minute, 0–59.
- `seconds` in 6: current second, 0–59.
- `alarm_enable` in 1: level; 0 forces IDLE and blocks matching.
- `set_valid` in 1: alarm-time load request.
- `set_hours` in 5: requested alarm hour.
- `set_minutes` in 6: requested alarm minute.
- `set_ready` out 1: load accepted this cycle when high together with `set_valid`.
- `set_err` out 1: one-cycle pulse when an accepted load is out of range.
- `snooze` in 1: one-cycle request.
- `stop` in 1: one-cycle request.
- `ring` out 1: alarm sounding.
- `snoozed` out 1: snooze pending.

## Operation
- Registers: `alm_h`/`alm_m` (reset 0/0), `tgt_h`/`tgt_m` (snooze target), an 8-bit ring counter, and the FSM state.
- Output reset values: `ring`=0, `snoozed`=0, `set_ready`=1, `set_err`=0. The FSM resets to IDLE.
- IDLE → RINGING when `alarm_enable` and `sec_tick` and `hours==alm_h` and `minutes==alm_m` and `seconds==0`.
  - Because `seconds==0` is required, the alarm cannot retrigger within the same minute after a stop.
- RINGING:
  - Ring counter clears on entry and increments on each `sec_tick`.
  - When the counter reaches `RING_SECONDS`, go to IDLE.
  - `stop` → IDLE.
  - `snooze` → SNOOZE, with the target loaded from the current `hours`/`minutes` plus `SNOOZE_MINUTES`:
    - If minutes ≥ 60, subtract 60 and add 1 hour.
    - Hour 24 wraps to 0.
- SNOOZE:
  - Go to RINGING on `sec_tick` with `hours==tgt_h`, `minutes==tgt_m`, `seconds==0`.
  - `stop` → IDLE.
  - `snooze` is ignored.
- Any state: `alarm_enable`=0 → IDLE on the next edge. This has priority over every other transition.
- `stop` and `snooze` in the same cycle: `stop` wins.
- `ring` is high in RINGING only. `snoozed` is high in SNOOZE only.
- Load handshake:
  - `set_ready` is high in IDLE only.
  - Transfer occurs on `set_valid && set_ready`.
  - If `set_hours` > 23 or `set_minutes` > 59, the alarm registers are unchanged and `set_err` pulses.
  - Otherwise `alm_h`/`alm_m` update.
  - A request outside IDLE stalls until the FSM returns to IDLE.
- A load in the same cycle as a match uses the old alarm value for that match.

## Timing
- `ring` rises on the first edge after the matching `sec_tick` cycle: 1-cycle latency.
- Timeout: `ring` falls on the edge after the `RING_SECONDS`-th `sec_tick` counted in RINGING.
- `stop`, `snooze`, and `alarm_enable` deassert take effect on the next edge: `ring`/`snoozed` update 1 cycle later.
- `set_err` is high for exactly the cycle after the transfer. `alm_h`/`alm_m` are visible to the comparator from that same cycle.
- Reset mid-operation: outputs return to reset values asynchronously and the alarm time returns to 00:00.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - SNOOZE state, target registers, and the wrap adder are present.
  - `snooze` behaves as described above.
- `ALARM_SNOOZE_EN` undefined:
  - SNOOZE state and target logic are not built.
  - `snooze` is ignored; RINGING exits only on `stop`, timeout, or disable.
  - `snoozed` is tied to 0.

## Test plan
- Load 08:00 and enable; drive time to 07:59:59, then tick to 08:00:00 → `ring` high 1 cycle after the tick. With no input, `ring` falls after 60 ticks at 08:01:00.
- Ring at 23:58; pulse `snooze` at 23:58:10 → `snoozed`=1 and the target is 00:03 (hour wrap). Tick to 00:03:00 → `ring`=1 and `snoozed`=0.
- While ringing, pulse `stop` and `snooze` in the same cycle → IDLE, with `ring`=0 and `snoozed`=0. Continue ticking through 08:00:59 → no retrigger.
- Load 24:00 → `set_err` pulse and the alarm stays 08:00. Assert `set_valid` with 06:30 while ringing → `set_ready`=0. After `stop`, the load transfers and the alarm reads 06:30.
- Assert `rst` mid-ring → `ring`=0 immediately and the alarm returns to 00:00. Toggle `alarm_enable` low during SNOOZE → IDLE, and no ring at the target.
- Build without `ALARM_SNOOZE_EN`: pulse `snooze` during ring → `ring` stays high until timeout, and `snoozed` stays 0.

Source files
------------

// File: rtl/alarm_unit_if.sv
// rtl/alarm_unit_if.sv - alarm-time load handshake bundle
interface alarm_unit_if;
  logic       set_valid;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       set_ready;
  logic       set_err;

  modport master (output set_valid, set_hours, set_minutes, input set_ready, set_err);
  modport slave  (input set_valid, set_hours, set_minutes, output set_ready, set_err);
endinterface

// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - alarm comparator/ringer with stop, timeout and load handshake
// Optional snooze state and wrap adder are built when ALARM_SNOOZE_EN is defined.
module alarm_unit #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sec_tick,
  input  logic [4:0]   hours,
  input  logic [5:0]   minutes,
  input  logic [5:0]   seconds,
  input  logic         alarm_enable,
  input  logic         snooze,
  input  logic         stop,
  output logic         ring,
  output logic         snoozed,
  alarm_unit_if.slave  set_if
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING
`ifdef ALARM_SNOOZE_EN
    , ST_SNOOZE
`endif
  } state_t;

  localparam logic [7:0] RING_LIM = 8'(RING_SECONDS);

  state_t     state, state_nxt;
  logic [4:0] alm_h;
  logic [5:0] alm_m;
  logic [7:0] ring_cnt;
  logic       set_err_q;
  logic       load_fire, load_bad, alarm_hit, cnt_done;

  assign load_fire = set_if.set_valid && set_if.set_ready;
  assign load_bad  = (set_if.set_hours > 5'd23) || (set_if.set_minutes > 6'd59);
  assign alarm_hit = sec_tick && (hours == alm_h) && (minutes == alm_m) && (seconds == 6'd0);
  // Counter holds ticks already seen in RINGING; this tick is the last one.
  assign cnt_done  = sec_tick && ((ring_cnt + 8'd1) == RING_LIM);

`ifdef ALARM_SNOOZE_EN
  localparam logic [6:0] SNZ_MIN = 7'(SNOOZE_MINUTES);

  logic [4:0] tgt_h, snz_h;
  logic [5:0] tgt_m, snz_m;
  logic [6:0] min_sum;
  logic       snz_hit;

  always_comb begin
    min_sum = {1'b0, minutes} + SNZ_MIN;
    snz_h   = hours;
    snz_m   = min_sum[5:0];
    if (min_sum >= 7'd60) begin
      snz_m = 6'(min_sum - 7'd60);
      snz_h = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
    end
  end

  assign snz_hit = sec_tick && (hours == tgt_h) && (minutes == tgt_m) && (seconds == 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_h <= 5'd0;
      tgt_m <= 6'd0;
    end else if (state == ST_RINGING && state_nxt == ST_SNOOZE) begin
      tgt_h <= snz_h;
      tgt_m <= snz_m;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_comb begin
    state_nxt = state;
    if (!alarm_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (alarm_hit) state_nxt = ST_RINGING;
        ST_RINGING: begin
          if (stop) state_nxt = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) state_nxt = ST_SNOOZE;
`endif
          else if (cnt_done) state_nxt = ST_IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop) state_nxt = ST_IDLE;
          else if (snz_hit) state_nxt = ST_RINGING;
        end
`endif
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      alm_h     <= 5'd0;
      alm_m     <= 6'd0;
      ring_cnt  <= 8'd0;
      set_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      set_err_q <= load_fire && load_bad;
      if (load_fire && !load_bad) begin
        alm_h <= set_if.set_hours;
        alm_m <= set_if.set_minutes;
      end
      // Held at zero outside RINGING, so every entry starts a fresh count.
      if (state != ST_RINGING) ring_cnt <= 8'd0;
      else if (sec_tick)       ring_cnt <= ring_cnt + 8'd1;
    end
  end

  assign ring             = (state == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
  assign snoozed          = (state == ST_SNOOZE);
`else
  assign snoozed          = 1'b0;
`endif
  assign set_if.set_ready = (state == ST_IDLE);
  assign set_if.set_err   = set_err_q;

endmodule

// File: tb/tb_alarm_unit.sv
// tb/tb_alarm_unit.sv - directed scoreboard bench for alarm_unit
module tb_alarm_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic [4:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       alarm_enable = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       ring, snoozed;

  alarm_unit_if set_if ();

  alarm_unit dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .hours(hours), .minutes(minutes),
    .seconds(seconds), .alarm_enable(alarm_enable), .snooze(snooze), .stop(stop),
    .ring(ring), .snoozed(snoozed), .set_if(set_if)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  int th = 0, tm = 0, ts = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
    push(tag, v);
    pop_chk(obs);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_time();
    hours = 5'(th);
    minutes = 6'(tm);
    seconds = 6'(ts);
  endtask

  task automatic jump(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
    put_time();
  endtask

  task automatic adv();
    ts++;
    if (ts == 60) begin ts = 0; tm++; end
    if (tm == 60) begin tm = 0; th++; end
    if (th == 24) th = 0;
  endtask

  // One strobe plus an idle cycle; the expected ring level is queued before the strobe.
  task automatic tick_exp(input string tag, input logic exp_ring);
    adv();
    put_time();
    push(tag, {31'd0, exp_ring});
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    pop_chk({31'd0, ring});
    cyc();
  endtask

  task automatic load(input int h, input int m);
    set_if.set_valid = 1'b1;
    set_if.set_hours = 5'(h);
    set_if.set_minutes = 6'(m);
    cyc();
    set_if.set_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_if.set_valid = 1'b0;
    set_if.set_hours = '0;
    set_if.set_minutes = '0;
    #12;
    chk("rst_ring", ring, 0);
    chk("rst_snoozed", snoozed, 0);
    chk("rst_set_ready", set_if.set_ready, 1);
    chk("rst_set_err", set_if.set_err, 0);
    cyc();
    rst = 1'b0;

    load(8, 0);
    chk("load_ok_err", set_if.set_err, 0);
    chk("load_ok_h", dut.alm_h, 8);
    chk("load_ok_m", dut.alm_m, 0);
    load(24, 0);
    chk("load_h24_err", set_if.set_err, 1);
    chk("load_h24_keep_h", dut.alm_h, 8);
    cyc();
    chk("err_one_cycle", set_if.set_err, 0);
    load(12, 60);
    chk("load_m60_err", set_if.set_err, 1);
    chk("load_m60_keep_m", dut.alm_m, 0);

    alarm_enable = 1'b1;
    jump(7, 59, 58);
    tick_exp("pre_match", 0);
    tick_exp("ring_rise", 1);
    for (int i = 1; i < 60; i++) tick_exp("ringing", 1);
    tick_exp("timeout_0801", 0);

    jump(7, 59, 59);
    tick_exp("ring_again", 1);
    tick_exp("ring_hold", 1);
    stop = 1'b1; snooze = 1'b1;
    cyc();
    stop = 1'b0; snooze = 1'b0;
    chk("stop_wins_ring", ring, 0);
    chk("stop_wins_snoozed", snoozed, 0);
    for (int i = 2; i < 61; i++) tick_exp("no_retrigger", 0);

    jump(7, 59, 59);
    tick_exp("ring_stall", 1);
    set_if.set_valid = 1'b1;
    set_if.set_hours = 5'd6;
    set_if.set_minutes = 6'd30;
    cyc();
    chk("stall_ready", set_if.set_ready, 0);
    cyc();
    chk("stall_keep_h", dut.alm_h, 8);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_ring", ring, 0);
    chk("post_stop_ready", set_if.set_ready, 1);
    cyc();
    set_if.set_valid = 1'b0;
    chk("stall_load_h", dut.alm_h, 6);
    chk("stall_load_m", dut.alm_m, 30);
    chk("stall_load_err", set_if.set_err, 0);

    jump(6, 29, 58);
    tick_exp("pre_0630", 0);
    tick_exp("ring_0630", 1);
`ifndef ALARM_SNOOZE_EN
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("nosnz_ring", ring, 1);
    chk("nosnz_snoozed", snoozed, 0);
    for (int i = 1; i < 60; i++) tick_exp("nosnz_ringing", 1);
    tick_exp("nosnz_timeout", 0);
`else
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    load(23, 58);
    jump(23, 57, 59);
    tick_exp("ring_2358", 1);
    jump(23, 58, 9);
    tick_exp("ring_235810", 1);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("snz_ring", ring, 0);
    chk("snz_snoozed", snoozed, 1);
    chk("snz_tgt_h", dut.tgt_h, 0);
    chk("snz_tgt_m", dut.tgt_m, 3);
    jump(0, 2, 58);
    tick_exp("snz_pre", 0);
    tick_exp("snz_ring_0003", 1);
    chk("snz_cleared", snoozed, 0);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("snz2_snoozed", snoozed, 1);
    alarm_enable = 1'b0;
    cyc();
    chk("snz_disable", snoozed, 0);
    alarm_enable = 1'b1;
    jump(0, 7, 59);
    tick_exp("snz_no_ring_0008", 0);
`endif

    load(5, 0);
    jump(4, 59, 59);
    adv();
    put_time();
    set_if.set_valid = 1'b1;
    set_if.set_hours = 5'd7;
    set_if.set_minutes = 6'd0;
    push("match_old_value", 1);
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    set_if.set_valid = 1'b0;
    pop_chk({31'd0, ring});
    chk("match_load_h", dut.alm_h, 7);
    alarm_enable = 1'b0;
    cyc();
    chk("disable_ring", ring, 0);
    alarm_enable = 1'b1;

    jump(6, 59, 59);
    tick_exp("ring_0700", 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ring", ring, 0);
    chk("rst_mid_ready", set_if.set_ready, 1);
    chk("rst_alm_h", dut.alm_h, 0);
    chk("rst_alm_m", dut.alm_m, 0);
    cyc();
    rst = 1'b0;
    jump(23, 59, 58);
    tick_exp("pre_midnight", 0);
    tick_exp("ring_midnight", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
